// File: rtl/ps2_pkg.sv
// ps2_pkg: shared state encoding, protocol byte constants and parity helper for the PS/2 host controller
package ps2_pkg;
  typedef enum logic [2:0] {IDLE, INHIBIT, START, SHIFT, ACKBIT, WAITRSP, NEXT} state_t;
  localparam logic [7:0] ACK = 8'hFA;
  localparam logic [7:0] RESEND = 8'hFE;
  localparam logic [7:0] SET_LED = 8'hED;
  function automatic logic odd_par(input logic [7:0] b);
    return ~^b;
  endfunction
endpackage

// File: rtl/ps2_filter.sv
// ps2_filter: line conditioning for PS/2 clock/data sense
//   ps2[0] clock: 2-flop sync + 8-sample glitch filter -> fall / clk_edge strobes
//   ps2[1] data : 2-flop sync only -> data
//   all sampling gated by ce; reset leaves every history bit at one (idle lines)
module ps2_filter (
  input  logic       clock,
  input  logic       reset,
  input  logic       ce,
  input  logic [1:0] ps2,
  output logic       fall,
  output logic       clk_edge,
  output logic       data
);
  logic [1:0] s1, s2;
  logic [7:0] hist;
  logic       lvl;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      s1   <= '1;
      s2   <= '1;
      hist <= '1;
      lvl  <= 1'b1;
    end else if (ce) begin
      s1   <= ps2;
      s2   <= s1;
      hist <= {hist[6:0], s2[0]};
      lvl  <= &hist ? 1'b1 : ~|hist ? 1'b0 : lvl;
    end
  // filtered level flips only after eight agreeing samples; strobes fire on that tick
  assign fall     = ce & lvl & ~|hist;
  assign clk_edge = ce & (lvl ? ~|hist : &hist);
  assign data     = s2[1];
endmodule

// File: rtl/ps2_host_ctrl.sv
// ps2_host_ctrl: PS/2 host-to-device transmitter arbitrating LED updates and single command bytes
//   clock/reset  system clock, async active-high reset; ce gates all activity
//   ps2/ps2_oe   raw line sense and open-drain pull-low, [0] clock, [1] data
//   led_req/led_val, cmd_req/cmd_byte  request pulses with captured payloads
//   rx_valid/rx_data  device byte from the scancode receiver; rx_own claims it
//   busy/done/err  transaction status
//   PS2_HOST_RETRY_EN: resend a byte on 0xFE or missing ack, up to 3 times
module ps2_host_ctrl
  import ps2_pkg::*;
#(
  parameter logic [15:0] INHIBIT_TICKS = 16'd800,
  parameter logic [15:0] TIMEOUT_TICKS = 16'd40000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ce,
  input  logic [1:0] ps2,
  output logic [1:0] ps2_oe,
  input  logic       led_req,
  input  logic [2:0] led_val,
  input  logic       cmd_req,
  input  logic [7:0] cmd_byte,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       rx_own,
  output logic       busy,
  output logic       done,
  output logic       err
);
  state_t      state, state_n;
  logic [15:0] cnt;
  logic [3:0]  bitcnt;
  logic [7:0]  tx, cmd_q;
  logic [2:0]  led_q;
  logic        is_led, second, cmd_pend, led_pend;
  logic        fall, clk_edge, data_s, tmo, fail, retry, fin_ok, fin_err;
  logic [8:0]  frame;
  ps2_filter u_filt (.clock, .reset, .ce, .ps2, .fall, .clk_edge, .data(data_s));
  assign frame  = {odd_par(tx), tx};
  assign tmo    = cnt == TIMEOUT_TICKS - 16'd1;
  assign busy   = state != IDLE;
  assign rx_own = state == WAITRSP;
  // SHIFT holds data+parity; the stop bit is the released line of ACKBIT
  assign ps2_oe = state == INHIBIT ? 2'b01 : state == START ? 2'b10 :
                  state == SHIFT ? {~frame[bitcnt], 1'b0} : 2'b00;
`ifdef PS2_HOST_RETRY_EN
  logic [1:0] tries;
  always_ff @(posedge clock or posedge reset)
    if (reset) tries <= '0;
    else if (ce) tries <= (state == IDLE || state == NEXT) ? 2'd0 : retry ? tries + 2'd1 : tries;
`endif
  always_comb begin
    state_n = state;
    fin_ok  = 1'b0;
    fin_err = 1'b0;
    fail    = 1'b0;
    case (state)
      IDLE:    state_n = (cmd_pend | led_pend) ? INHIBIT : IDLE;
      INHIBIT: state_n = (cnt == INHIBIT_TICKS - 16'd1) ? START : INHIBIT;
      START:   if (fall) state_n = SHIFT; else fin_err = tmo;
      SHIFT:   if (fall) state_n = bitcnt == 4'd8 ? ACKBIT : SHIFT; else fin_err = tmo;
      ACKBIT:  if (fall) begin
                 state_n = WAITRSP;
                 fail    = data_s;
               end else fin_err = tmo;
      WAITRSP: if (rx_valid) begin
                 state_n = NEXT;
                 fin_ok  = rx_data == ACK && !(is_led && !second);
                 fail    = rx_data == RESEND;
                 fin_err = rx_data != ACK && rx_data != RESEND;
               end else fin_err = tmo;
      NEXT:    state_n = INHIBIT;
      default: state_n = IDLE;
    endcase
`ifdef PS2_HOST_RETRY_EN
    retry = fail & (tries != 2'd3);
`else
    retry = 1'b0;
`endif
    fin_err = fin_err | (fail & ~retry);
    if (retry) state_n = INHIBIT;
    if (fin_ok | fin_err) state_n = IDLE;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      bitcnt   <= '0;
      tx       <= '0;
      cmd_q    <= '0;
      led_q    <= '0;
      is_led   <= 1'b0;
      second   <= 1'b0;
      cmd_pend <= 1'b0;
      led_pend <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else if (ce) begin
      state    <= state_n;
      // our own clock pull during INHIBIT must not restart the inhibit count
      cnt      <= (state_n != state || (clk_edge && state != INHIBIT)) ? '0 : cnt + 16'd1;
      bitcnt   <= state == SHIFT ? bitcnt + {3'b0, fall} : '0;
      done     <= fin_ok;
      err      <= fin_err;
      cmd_pend <= cmd_req | (cmd_pend & state != IDLE);
      led_pend <= led_req | (led_pend & !(state == IDLE && !cmd_pend));
      if (cmd_req) cmd_q <= cmd_byte;
      if (led_req) led_q <= led_val;
      if (state == IDLE) begin
        tx     <= cmd_pend ? cmd_q : SET_LED;
        is_led <= ~cmd_pend;
        second <= 1'b0;
      end else if (state == NEXT) begin
        tx     <= {5'b0, led_q};
        second <= 1'b1;
      end
    end
endmodule

// File: doc/ps2_host_ctrl.md
PS2_HOST_CTRL -- requirements
Module: ps2_host_ctrl

Interface
REQ-001 Parameter INHIBIT_TICKS, default 16'd800, ce ticks the PS/2 clock line is held low before a transmit (100 us at 8 MHz ce).
REQ-002 Parameter TIMEOUT_TICKS, default 16'd40000, ce ticks allowed per phase (device clocking, ack bit, response byte).
REQ-003 clock  in  1  system clock; one clock domain; all state changes on rising edge.
REQ-004 reset  in  1  asynchronous, active-high.
REQ-005 ce  in  1  clock enable; all sampling, counting and state changes happen only when ce=1.
REQ-006 ps2  in  2  line sense: [0] PS/2 clock, [1] PS/2 data, both raw and asynchronous.
REQ-007 ps2_oe  out  2  open-drain pull-low: [0] clock, [1] data; 1 = drive low, 0 = release.
REQ-008 led_req  in  1  pulse, requester A: update keyboard LEDs.
REQ-009 led_val  in  3  LED mask {caps, num, scroll}, captured on led_req.
REQ-010 cmd_req  in  1  pulse, requester B: send single command byte.
REQ-011 cmd_byte  in  8  command byte, captured on cmd_req.
REQ-012 rx_valid  in  1  one-ce-tick strobe from the scancode receiver: byte received.
REQ-013 rx_data  in  8  byte received from the device.
REQ-014 rx_own  out  1  high while a device response belongs to this block; the scancode decoder discards bytes while high.
REQ-015 busy  out  1  high from request acceptance to completion.
REQ-016 done  out  1  one-ce-tick pulse, transaction acknowledged.
REQ-017 err  out  1  one-ce-tick pulse, transaction failed.

Function
REQ-018 States: IDLE, INHIBIT, START, SHIFT, ACKBIT, WAITRSP, NEXT.
REQ-019 Pending-request flags latch led_req/cmd_req in any state; a flag clears when its transaction starts; a duplicate request while pending overwrites the captured value.
REQ-020 Arbitration in IDLE: cmd pending beats led pending; a transaction is never preempted.
REQ-021 LED transaction sends 0xED, waits for 0xFA, then sends {5'b0, led_val}; cmd transaction sends cmd_byte only.
REQ-022 INHIBIT: ps2_oe=2'b01 for exactly INHIBIT_TICKS ticks, then START: ps2_oe=2'b10 (clock released, data low).
REQ-023 SHIFT: on each filtered device-clock falling edge, drive the next of: 8 data bits LSB first, odd parity, stop bit (released); data bit 1 = release, bit 0 = pull low.
REQ-024 ACKBIT: after the stop bit, ps2_oe=2'b00; data sampled low on the next falling edge = ack, else error.
REQ-025 WAITRSP: rx_own=1; rx_data 0xFA -> NEXT (second LED byte) or done; any other byte -> error.
REQ-026 Timeout counter restarts on every state entry and every device-clock edge; reaching TIMEOUT_TICKS in SHIFT/ACKBIT/WAITRSP -> error.
REQ-027 Error: err pulse, ps2_oe=2'b00, return to IDLE, remaining bytes dropped.
REQ-028 done/err assert on the tick the transaction ends; busy falls on the same tick.
REQ-029 Parity generated over the 8 transmitted bits; odd parity (0x00 -> parity bit 1).

Reset
REQ-030 Asynchronous reset: state IDLE, ps2_oe=2'b00, rx_own=0, busy=0, done=0, err=0, pending flags and counters cleared; filter history all ones.
REQ-031 Reset mid-transaction releases both lines immediately, with no done or err pulse.

Configuration
REQ-032 PS2_HOST_RETRY_EN defined: a 0xFE response or missing ack bit resends the current byte from INHIBIT up to 3 times, and err fires only on the 4th failure; undefined: any failure ends the transaction with err.

Structure
REQ-033 Shared package ps2_pkg: state encoding, constants ACK=8'hFA, RESEND=8'hFE, SET_LED=8'hED.
REQ-034 Sub-module ps2_filter: 2-flop synchroniser plus 8-sample glitch filter on ps2[0], outputting a falling-edge strobe; ps2[1] uses the 2-flop synchroniser only.

Verification
REQ-035 cmd_req with cmd_byte=0xFF, device model acks -> clock low 800 ticks, serial bits 1111_1111, parity 1, stop, then rx 0xFA -> done once, busy low.
REQ-036 led_req with led_val=3'b101 -> bytes 0xED, 0xFA from device, then 0x05 with parity 1, 0xFA -> a single done.
REQ-037 led_req and cmd_req on the same tick -> cmd byte transmitted first, LED transaction follows automatically, two done pulses.
REQ-038 Device stops clocking after bit 3 -> err after TIMEOUT_TICKS, ps2_oe=2'b00.
REQ-039 Device answers 0xFE -> err without macro; with PS2_HOST_RETRY_EN, byte resent and 0xFA on the retry -> done.
REQ-040 reset asserted during SHIFT -> ps2_oe=2'b00 at once; after release a new cmd_req completes normally.
